// File: rtl/sram_seq_pkg.sv
// Shared types for the SRAM sample sequencer: FSM states, record field widths and the
// 65-bit stored traffic-training record.
package sram_seq_pkg;

  localparam int TW     = 7;
  localparam int OW     = 14;
  localparam int TIME_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    PRES = 3'd2,
    WR   = 3'd3,
    NEXT = 3'd4
  } state_e;

  typedef struct packed {
    logic [TW-1:0]     TNS;
    logic [TW-1:0]     TEW;
    logic [TW-1:0]     PNS;
    logic [TW-1:0]     PEW;
    logic [OW-1:0]     NSout;
    logic [OW-1:0]     EWout;
    logic              dir;
    logic [TIME_W-1:0] dTime;
  } record_t;

  // A record with no traffic or pedestrian counts carries nothing worth calibrating.
  function automatic logic is_empty(input record_t r);
    return (r.TNS == '0) && (r.TEW == '0) && (r.PNS == '0) && (r.PEW == '0);
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Record address walker: loads the window start, steps by one with natural
// wrap at 2^ADDR_W, and flags when the current address is the window end.
module seq_addr_gen #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] last_i,
  output logic [ADDR_W-1:0] cur_o,
  output logic              at_last_o
);

  logic [ADDR_W-1:0] cur_q, cur_d;

  always_comb begin
    cur_d = cur_q;
    if (load_i) begin
      cur_d = load_val_i;
    end else if (inc_i) begin
      cur_d = cur_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign cur_o     = cur_q;
  assign at_last_o = (cur_q == last_i);

endmodule

// File: rtl/sram_sample_sequencer.sv
// Walks an SRAM address window, reads each record, holds it for the calibrator and
// optionally writes calibrated fields back. Define SKIP_EMPTY_EN to skip all-zero records.
module sram_sample_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  parameter int WR_CYC = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [TW-1:0]     rTNS,
  input  logic [TW-1:0]     rTEW,
  input  logic [TW-1:0]     rPNS,
  input  logic [TW-1:0]     rPEW,
  input  logic [OW-1:0]     rNSout,
  input  logic [OW-1:0]     rEWout,
  input  logic              rdir,
  input  logic [TIME_W-1:0] rdTime,
  output logic [TW-1:0]     iTNS,
  output logic [TW-1:0]     iTEW,
  output logic [TW-1:0]     iPNS,
  output logic [TW-1:0]     iPEW,
  output logic [OW-1:0]     iNSout,
  output logic [OW-1:0]     iEWout,
  output logic              idir,
  output logic [TIME_W-1:0] idTime,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [TW-1:0]     TNS,
  output logic [TW-1:0]     TEW,
  output logic [TW-1:0]     PNS,
  output logic [TW-1:0]     PEW,
  output logic [OW-1:0]     NSout,
  output logic [OW-1:0]     EWout,
  output logic              dir,
  output logic [TIME_W-1:0] dTime,
  input  logic              wb_req,
  input  logic [OW-1:0]     wb_NSout,
  input  logic [OW-1:0]     wb_EWout,
  input  logic              wb_dir,
  input  logic [TIME_W-1:0] wb_dTime,
  output logic              busy,
  output logic              pass_done
);

  localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_CYC - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  record_t           hold_q, hold_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              pend_q, pend_d;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_inc;
  logic [ADDR_W-1:0] cur;
  logic              at_last;
  record_t           rec_in;

  assign rec_in = {rTNS, rTEW, rPNS, rPEW, rNSout, rEWout, rdir, rdTime};

  seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (ag_load),
    .load_val_i (ag_load_val),
    .inc_i      (ag_inc),
    .last_i     (last_q),
    .cur_o      (cur),
    .at_last_o  (at_last)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    smp_addr_d  = smp_addr_q;
    first_d     = first_q;
    last_d      = last_q;
    pend_d      = pend_q;
    ag_load     = 1'b0;
    ag_load_val = first_q;
    ag_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          first_d     = first_addr;
          last_d      = last_addr;
          ag_load     = 1'b1;
          ag_load_val = first_addr;
          cnt_d       = '0;
          state_d     = RD;
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          hold_d     = rec_in;
          smp_addr_d = cur;
          cnt_d      = '0;
`ifdef SKIP_EMPTY_EN
          state_d    = is_empty(rec_in) ? NEXT : PRES;
`else
          state_d    = PRES;
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      PRES: begin
        // Write-back takes priority; a simultaneous ready is remembered and honoured after it.
        if (wb_req) begin
          hold_d.NSout = wb_NSout;
          hold_d.EWout = wb_EWout;
          hold_d.dir   = wb_dir;
          hold_d.dTime = wb_dTime;
          pend_d       = smp_ready;
          cnt_d        = '0;
          state_d      = WR;
        end else if (smp_ready) begin
          state_d = NEXT;
        end
      end
      WR: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = pend_q ? NEXT : PRES;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (at_last) begin
          if (loop_en) begin
            ag_load = 1'b1;
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ag_inc  = 1'b1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything but leaves the held record untouched.
    if (abort) begin
      state_d    = IDLE;
      cnt_d      = '0;
      pend_d     = 1'b0;
      hold_d     = hold_q;
      smp_addr_d = smp_addr_q;
      ag_load    = 1'b0;
      ag_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_q     <= '0;
      smp_addr_q <= '0;
      first_q    <= '0;
      last_q     <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      smp_addr_q <= smp_addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
    end
  end

  assign read      = (state_q == RD);
  assign write     = (state_q == WR);
  assign smp_valid = (state_q == PRES);
  assign busy      = (state_q != IDLE);
  assign pass_done = (state_q == NEXT) && at_last;
  assign addr      = (state_q == WR) ? smp_addr_q : cur;
  assign smp_addr  = smp_addr_q;

  assign TNS   = hold_q.TNS;
  assign TEW   = hold_q.TEW;
  assign PNS   = hold_q.PNS;
  assign PEW   = hold_q.PEW;
  assign NSout = hold_q.NSout;
  assign EWout = hold_q.EWout;
  assign dir   = hold_q.dir;
  assign dTime = hold_q.dTime;

  // Write data is the held record, whose write-back fields were refreshed on WR entry.
  assign iTNS   = hold_q.TNS;
  assign iTEW   = hold_q.TEW;
  assign iPNS   = hold_q.PNS;
  assign iPEW   = hold_q.PEW;
  assign iNSout = hold_q.NSout;
  assign iEWout = hold_q.EWout;
  assign idir   = hold_q.dir;
  assign idTime = hold_q.dTime;

endmodule

// File: tb/tb_sram_sample_sequencer.sv
// Directed bench for sram_sample_sequencer: window-walk vector table plus hand-written
// write-back, stall, abort and reset sequences against a behavioural SRAM.
module tb_sram_sample_sequencer;
  import sram_seq_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst, start, abort, loop_en;
  logic [11:0] first_addr, last_addr, addr, smp_addr;
  logic        read, write, smp_valid, smp_ready, busy, pass_done;
  logic [6:0]  rTNS, rTEW, rPNS, rPEW, iTNS, iTEW, iPNS, iPEW, TNS, TEW, PNS, PEW;
  logic [13:0] rNSout, rEWout, iNSout, iEWout, NSout, EWout, wb_NSout, wb_EWout;
  logic        rdir, idir, dir, wb_dir, wb_req;
  logic [7:0]  rdTime, idTime, dTime, wb_dTime;

  always #5 clk = ~clk;

  sram_sample_sequencer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .loop_en(loop_en),
    .first_addr(first_addr), .last_addr(last_addr),
    .read(read), .write(write), .addr(addr),
    .rTNS(rTNS), .rTEW(rTEW), .rPNS(rPNS), .rPEW(rPEW),
    .rNSout(rNSout), .rEWout(rEWout), .rdir(rdir), .rdTime(rdTime),
    .iTNS(iTNS), .iTEW(iTEW), .iPNS(iPNS), .iPEW(iPEW),
    .iNSout(iNSout), .iEWout(iEWout), .idir(idir), .idTime(idTime),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_addr(smp_addr),
    .TNS(TNS), .TEW(TEW), .PNS(PNS), .PEW(PEW),
    .NSout(NSout), .EWout(EWout), .dir(dir), .dTime(dTime),
    .wb_req(wb_req), .wb_NSout(wb_NSout), .wb_EWout(wb_EWout),
    .wb_dir(wb_dir), .wb_dTime(wb_dTime),
    .busy(busy), .pass_done(pass_done)
  );

  // Default SRAM contents are a fixed function of the address.
  function automatic record_t exp_rec(input logic [11:0] a);
    record_t    r;
    logic [6:0] b;
    b       = a[6:0];
    r.TNS   = b + 7'd1;
    r.TEW   = b ^ 7'h2A;
    r.PNS   = b + 7'd9;
    r.PEW   = ~b;
    r.NSout = {a, 2'b01};
    r.EWout = {2'b10, ~a};
    r.dir   = a[0];
    r.dTime = a[7:0] ^ 8'hC3;
`ifdef SKIP_EMPTY_EN
    if (a == 12'd2) begin
      r.TNS = '0; r.TEW = '0; r.PNS = '0; r.PEW = '0;
    end
`endif
    return r;
  endfunction

  record_t ovr [0:4095];
  bit      ovr_vld [0:4095];
  record_t rd_rec;

  always_comb rd_rec = ovr_vld[addr] ? ovr[addr] : exp_rec(addr);
  assign {rTNS, rTEW, rPNS, rPEW, rNSout, rEWout, rdir, rdTime} = rd_rec;

  always @(posedge clk) begin
    if (write) begin
      ovr[addr]     <= {iTNS, iTEW, iPNS, iPEW, iNSout, iEWout, idir, idTime};
      ovr_vld[addr] <= 1'b1;
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [11:0]       first;
    logic [11:0]       last;
    logic              loop;
    int                n;
    int                exp_pass;
    int                exp_rd;
    logic [7:0][11:0]  exp;
  } vec_t;

  function automatic vec_t mkv(input logic [11:0] f, l, input logic lp, input int n, pass, rd,
                               input logic [11:0] e0, e1, e2, e3, e4, e5, e6);
    vec_t v;
    v.first = f; v.last = l; v.loop = lp; v.n = n; v.exp_pass = pass; v.exp_rd = rd;
    v.exp = {12'd0, e6, e5, e4, e3, e2, e1, e0};
    return v;
  endfunction

  vec_t        vt [4];
  vec_t        cur_v;
  logic        mon_en = 1'b0;
  int          sc_seq = 0;
  int          seen_seq = 0;
  int          hs_cnt = 0, pass_cnt = 0, rd_cnt = 0;
  logic [11:0] rd_next = '0;
  logic        read_prev = 1'b0;
  record_t     out_rec;

  // Observer: read/write exclusion always; strobe order, records and passes while enabled.
  always @(negedge clk) begin
    chk("rd_wr_excl", {64'd0, read & write}, 65'd0);
    if (mon_en) begin
      if (sc_seq != seen_seq) begin
        seen_seq = sc_seq;
        hs_cnt   = 0;
        pass_cnt = 0;
        rd_cnt   = 0;
        rd_next  = cur_v.first;
      end
      if (read && !read_prev) begin
        chk("rd_strobe_addr", {53'd0, addr}, {53'd0, rd_next});
        rd_cnt++;
        rd_next = (rd_next == cur_v.last) ? cur_v.first : rd_next + 12'd1;
      end
      if (smp_valid && smp_ready) begin
        if (hs_cnt < 8) begin
          out_rec = {TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime};
          chk("rec_addr", {53'd0, smp_addr}, {53'd0, cur_v.exp[hs_cnt]});
          chk("rec_data", out_rec, exp_rec(cur_v.exp[hs_cnt]));
        end
        hs_cnt++;
      end
      if (pass_done) pass_cnt++;
    end
    read_prev = read;
  end

  task automatic go(input logic [11:0] f, l, input logic lp);
    @(posedge clk); #1;
    first_addr = f; last_addr = l; loop_en = lp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_abort;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int c;
    c = 0;
    while (!smp_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(nm, {64'd0, smp_valid}, 65'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    record_t r;
    int      wcnt, pseen, rdseen;

    n_rst = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    first_addr = '0; last_addr = '0; smp_ready = 1'b0;
    wb_req = 1'b0; wb_NSout = '0; wb_EWout = '0; wb_dir = 1'b0; wb_dTime = '0;

`ifdef SKIP_EMPTY_EN
    vt[0] = mkv(12'd0, 12'd3, 1'b0, 3, 1, 4, 12'd0, 12'd1, 12'd3, 12'd0, 12'd0, 12'd0, 12'd0);
`else
    vt[0] = mkv(12'd0, 12'd3, 1'b0, 4, 1, 4, 12'd0, 12'd1, 12'd2, 12'd3, 12'd0, 12'd0, 12'd0);
`endif
    vt[1] = mkv(12'd4094, 12'd1, 1'b1, 6, 1, 0,
                12'd4094, 12'd4095, 12'd0, 12'd1, 12'd4094, 12'd4095, 12'd0);
    vt[2] = mkv(12'd5, 12'd5, 1'b0, 1, 1, 1, 12'd5, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
    vt[3] = mkv(12'd10, 12'd12, 1'b1, 7, 2, 0,
                12'd10, 12'd11, 12'd12, 12'd10, 12'd11, 12'd12, 12'd10);
    cur_v = vt[0];

    #12;
    chk("rst_read", {64'd0, read}, 65'd0);
    chk("rst_write", {64'd0, write}, 65'd0);
    chk("rst_smp_valid", {64'd0, smp_valid}, 65'd0);
    chk("rst_busy", {64'd0, busy}, 65'd0);
    chk("rst_pass_done", {64'd0, pass_done}, 65'd0);
    chk("rst_addr", {53'd0, addr}, 65'd0);
    chk("rst_hold", {TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime}, 65'd0);
    chk("rst_smp_addr", {53'd0, smp_addr}, 65'd0);
    @(posedge clk); #1 n_rst = 1'b1;

    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_v = vt[i];
      @(posedge clk); #1;
      sc_seq++;
      first_addr = cur_v.first; last_addr = cur_v.last; loop_en = cur_v.loop;
      smp_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 3000 && hs_cnt < cur_v.n; c++) @(posedge clk);
      #1;
      chk("vec_records", hs_cnt, cur_v.n);
      if (cur_v.loop) begin
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end else begin
        for (int c = 0; c < 100 && busy; c++) @(negedge clk);
      end
      @(negedge clk);
      chk("vec_busy_end", {64'd0, busy}, 65'd0);
      chk("vec_pass_cnt", pass_cnt, cur_v.exp_pass);
      if (cur_v.exp_rd > 0) chk("vec_read_cnt", rd_cnt, cur_v.exp_rd);
      smp_ready = 1'b0;
    end
    mon_en = 1'b0;

    // Write-back at 30 with a simultaneous ready: write first, then the pass ends.
    r = exp_rec(12'd30);
    go(12'd30, 12'd30, 1'b0);
    wait_valid("wb_pres_valid");
    chk("wb_pres_addr", {53'd0, smp_addr}, 65'd30);
    chk("wb_pres_NSout", {51'd0, NSout}, {51'd0, r.NSout});
    wb_req = 1'b1; smp_ready = 1'b1;
    wb_NSout = 14'h9A; wb_EWout = 14'h9B; wb_dir = 1'b1; wb_dTime = 8'h12;
    @(posedge clk); #1 wb_req = 1'b0; smp_ready = 1'b0;
    @(negedge clk);
    chk("wb_write", {64'd0, write}, 65'd1);
    chk("wb_read_low", {64'd0, read}, 65'd0);
    chk("wb_addr", {53'd0, addr}, 65'd30);
    chk("wb_valid_low", {64'd0, smp_valid}, 65'd0);
    chk("wb_iTraffic", {37'd0, iTNS, iTEW, iPNS, iPEW}, {37'd0, r.TNS, r.TEW, r.PNS, r.PEW});
    chk("wb_iNSout", {51'd0, iNSout}, 65'h9A);
    chk("wb_iEWout", {51'd0, iEWout}, 65'h9B);
    chk("wb_idir", {64'd0, idir}, 65'd1);
    chk("wb_idTime", {57'd0, idTime}, 65'h12);
    chk("wb_hold_NSout", {51'd0, NSout}, 65'h9A);
    wcnt = 1; pseen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (write) wcnt++;
      if (pass_done) pseen++;
    end
    chk("wb_write_cycles", wcnt, 2);
    chk("wb_pass_done", pseen, 1);
    chk("wb_busy_end", {64'd0, busy}, 65'd0);

    go(12'd30, 12'd30, 1'b0);
    wait_valid("reread_valid");
    chk("reread_traffic", {37'd0, TNS, TEW, PNS, PEW}, {37'd0, r.TNS, r.TEW, r.PNS, r.PEW});
    chk("reread_NSout", {51'd0, NSout}, 65'h9A);
    chk("reread_EWout", {51'd0, EWout}, 65'h9B);
    chk("reread_dir", {64'd0, dir}, 65'd1);
    chk("reread_dTime", {57'd0, dTime}, 65'h12);
    do_abort();

    // Stall: no ready for 10 cycles keeps the record frozen and the bus quiet.
    r = exp_rec(12'd40);
    go(12'd40, 12'd41, 1'b0);
    wait_valid("stall_valid0");
    rdseen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", {64'd0, smp_valid}, 65'd1);
      chk("stall_addr", {53'd0, smp_addr}, 65'd40);
      chk("stall_rec", {TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime}, r);
      if (read) rdseen++;
    end
    chk("stall_no_reads", rdseen, 0);
    do_abort();
    @(negedge clk);
    chk("stall_abort_busy", {64'd0, busy}, 65'd0);

    // Abort during RD: everything drops next cycle, held record survives.
    go(12'd50, 12'd60, 1'b0);
    @(negedge clk);
    chk("abrd_read_active", {64'd0, read}, 65'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abrd_read", {64'd0, read}, 65'd0);
    chk("abrd_busy", {64'd0, busy}, 65'd0);
    chk("abrd_valid", {64'd0, smp_valid}, 65'd0);
    chk("abrd_hold_kept", {TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime}, r);

    // Abort during WR.
    go(12'd70, 12'd70, 1'b0);
    wait_valid("abwr_valid");
    wb_req = 1'b1;
    @(posedge clk); #1 wb_req = 1'b0;
    @(negedge clk);
    chk("abwr_write_active", {64'd0, write}, 65'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abwr_write", {64'd0, write}, 65'd0);
    chk("abwr_busy", {64'd0, busy}, 65'd0);

    // Start while busy is ignored.
    go(12'd80, 12'd82, 1'b0);
    wait_valid("busy_start_valid");
    chk("busy_start_addr0", {53'd0, smp_addr}, 65'd80);
    first_addr = 12'd90; last_addr = 12'd90; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_start_held", {64'd0, smp_valid}, 65'd1);
    chk("busy_start_addr1", {53'd0, smp_addr}, 65'd80);
    smp_ready = 1'b1;
    @(posedge clk); #1 smp_ready = 1'b0;
    wait_valid("busy_start_next_valid");
    chk("busy_start_addr2", {53'd0, smp_addr}, 65'd81);
    do_abort();

    // Asynchronous reset in the middle of a write-back.
    go(12'd100, 12'd100, 1'b0);
    wait_valid("rstwr_valid");
    wb_req = 1'b1;
    @(posedge clk); #1 wb_req = 1'b0;
    @(negedge clk);
    chk("rstwr_write_active", {64'd0, write}, 65'd1);
    #1 n_rst = 1'b0;
    #1;
    chk("rstwr_write", {64'd0, write}, 65'd0);
    chk("rstwr_busy", {64'd0, busy}, 65'd0);
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);
    chk("rstwr_hold_clear", {TNS, TEW, PNS, PEW, NSout, EWout, dir, dTime}, 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_sample_sequencer.md
Name: sram_sample_sequencer

Overview:
- Upstream master of the SRAM controller's NN-side read/write port.
- Walks a programmed address window of stored traffic-training records and reads each record through the controller.
- Presents each record to the calibrator on a valid/ready handshake.
- Optionally writes calibrated outputs back to the same record address. Sits between the sequencing control and sramcontrol/calibrator.

Parameters:
- ADDR_W, 12, SRAM address width.
- RD_LAT, 2, cycles from read assertion to valid controller output data (1..7).
- WR_CYC, 2, cycles write is held asserted per write-back (1..7).

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass at first_addr
- abort  in  1  return to IDLE at next edge, dropping any transaction
- loop_en  in  1  1: wrap to first_addr after last_addr; 0: stop
- first_addr  in  ADDR_W  window start, sampled on start
- last_addr  in  ADDR_W  window end inclusive, sampled on start
- read  out  1  read request to controller
- write  out  1  write request to controller
- addr  out  ADDR_W  controller address
- rTNS/rTEW/rPNS/rPEW  in  7 each  controller read data
- rNSout/rEWout  in  14 each  controller read data
- rdir  in  1; rdTime  in  8  controller read data
- iTNS/iTEW/iPNS/iPEW  out  7 each  write data to controller
- iNSout/iEWout  out  14 each; idir  out  1; idTime  out  8  write data to controller
- smp_valid  out  1  record held for calibrator
- smp_ready  in  1  calibrator accepts record
- smp_addr  out  ADDR_W  address of held record
- TNS/TEW/PNS/PEW/NSout/EWout/dir/dTime  out  as above  held record
- wb_req  in  1  write-back request, only honoured while smp_valid
- wb_NSout/wb_EWout  in  14 each; wb_dir  in  1; wb_dTime  in  8  write-back data
- busy  out  1  not IDLE
- pass_done  out  1  one-cycle pulse after last_addr record is consumed

Behaviour:
- Reset: all outputs 0, state IDLE, internal address and start/end registers 0.
- States:
  - IDLE → RD on start, or stays in IDLE.
  - RD: read=1, addr=cur; counter runs RD_LAT cycles, then capture all r* fields into the hold registers → PRES.
  - PRES: smp_valid=1, record stable.
    - smp_ready=1 → NEXT.
    - Else wb_req=1 → WR.
    - smp_ready and wb_req in the same cycle → WR first; the ready is consumed on WR exit.
  - WR: write=1 for WR_CYC cycles, addr=smp_addr. Write data is the held TNS/TEW/PNS/PEW plus the wb_* values, which are latched on entry. Hold registers NSout/EWout/dir/dTime update to the wb_* values. Then → NEXT, or → PRES if no pending ready.
  - NEXT: if cur==last_addr, pulse pass_done; with loop_en, cur=first_addr → RD, otherwise → IDLE. If cur!=last_addr, cur=cur+1 → RD.
- read and write are never high together; both are 0 outside RD/WR.
- Record latency: start to smp_valid = RD_LAT+1 cycles.
- first_addr>last_addr: cur increments mod 2^ADDR_W until it equals last_addr (wrap-around).
- first_addr==last_addr: single record per pass.
- start while busy is ignored.
- abort wins over all other events. Next state is IDLE, read/write/smp_valid drop the next cycle, and hold registers keep their values.
- Asynchronous reset mid-write drops write immediately.

Optional Feature:
- SKIP_EMPTY_EN defined: a captured record with TNS=TEW=PNS=PEW=0 skips PRES and goes directly to NEXT; pass_done still fires on last_addr.
- Not defined: every record is presented.

Decomposition:
- Package sram_seq_pkg:
  - state enum {IDLE,RD,PRES,WR,NEXT}
  - field widths TW=7, OW=14, TIME_W=8
  - packed struct record_t {TNS,TEW,PNS,PEW,NSout,EWout,dir,dTime} (65 bits)
- One sub-module: seq_addr_gen (cur register, load first, increment with wrap, at_last flag).

Test Plan:
- first=0,last=3,loop_en=0, smp_ready tied 1 → read strobes at addr 0,1,2,3, four smp_valid records matching SRAM contents, pass_done once, busy falls.
- Record at 30 presented, wb_req with wb_NSout=0x9A, wb_EWout=0x9B, wb_dir=1, wb_dTime=0x12 → write=1 for 2 cycles at addr 30, iTNS..iPEW unchanged. Re-read returns the new values.
- first=4094,last=1,loop_en=1 → order 4094,4095,0,1,4094…; pass_done after addr 1 every pass.
- smp_ready held 0 for 10 cycles → smp_valid and all fields stable, no further read strobes.
- abort asserted mid-RD and mid-WR → IDLE next cycle, read/write 0, busy 0; start pulse during busy ignored.
- SKIP_EMPTY_EN: record at addr 2 all-zero traffic/ped → only addr 0,1,3 presented.
